// File: rtl/multichannel_inputconditioner.sv
// Per-channel input conditioner: 2-flop synchroniser, run-time debounce, edge pulses, any-edge flags.
// Optional per-channel glitch counters are built when GLITCH_COUNT_EN is defined.
module multichannel_inputconditioner #(
  parameter int                  CHANNELS     = 4,
  parameter int                  COUNTERWIDTH = 3,
  parameter logic [CHANNELS-1:0] INITVAL      = '0,
  parameter logic [CHANNELS-1:0] INVERT       = '0,
  parameter int                  GLITCHWIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             noisysignal,
  input  logic [CHANNELS-1:0]             enable,
  input  logic [COUNTERWIDTH-1:0]         waittime,
  input  logic                            glitchclear,
  output logic [CHANNELS-1:0]             conditioned,
  output logic [CHANNELS-1:0]             positiveedge,
  output logic [CHANNELS-1:0]             negativeedge,
  output logic                            anyposedge,
  output logic                            anynegedge,
  output logic [CHANNELS*GLITCHWIDTH-1:0] glitchcount
);

  logic [CHANNELS-1:0]     sync_p0;
  logic [CHANNELS-1:0]     sync_p1;
  logic [CHANNELS-1:0]     cond_q;
  logic [CHANNELS-1:0]     pos_q;
  logic [CHANNELS-1:0]     neg_q;
  logic [COUNTERWIDTH-1:0] cnt_q [CHANNELS];

  logic [CHANNELS-1:0]     mismatch;
  logic [CHANNELS-1:0]     commit;

  always_comb begin
    mismatch = '0;
    commit   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mismatch[i] = sync_p1[i] != cond_q[i];
      commit[i]   = enable[i] && mismatch[i] && (cnt_q[i] >= waittime);
    end
  end

  // Synchroniser stages reset to INITVAL so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= INITVAL;
      sync_p1 <= INITVAL;
      cond_q  <= INITVAL;
      pos_q   <= '0;
      neg_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      sync_p0 <= noisysignal ^ INVERT;
      sync_p1 <= sync_p0;
      cond_q  <= (cond_q & ~commit) | (sync_p1 & commit);
      pos_q   <= commit & sync_p1;
      neg_q   <= commit & ~sync_p1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!enable[i] || !mismatch[i] || commit[i]) cnt_q[i] <= '0;
        else                                         cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign anyposedge   = |pos_q;
  assign anynegedge   = |neg_q;

`ifdef GLITCH_COUNT_EN
  function automatic logic [GLITCHWIDTH-1:0] sat_inc(input logic [GLITCHWIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CHANNELS-1:0]    abort;
  logic [GLITCHWIDTH-1:0] gcnt_q [CHANNELS];

  // An aborted debounce attempt: count was running but the input came back into agreement.
  always_comb begin
    abort = '0;
    for (int i = 0; i < CHANNELS; i++)
      abort[i] = enable[i] && !mismatch[i] && (cnt_q[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (glitchclear)   gcnt_q[i] <= '0;
        else if (abort[i]) gcnt_q[i] <= sat_inc(gcnt_q[i]);
      end
    end
  end

  always_comb begin
    glitchcount = '0;
    for (int i = 0; i < CHANNELS; i++)
      glitchcount[i*GLITCHWIDTH +: GLITCHWIDTH] = gcnt_q[i];
  end
`else
  logic glitchclear_unused;
  assign glitchclear_unused = glitchclear;
  assign glitchcount        = '0;
`endif

endmodule

// File: tb/tb_multichannel_inputconditioner.sv
// Bench for multichannel_inputconditioner: table vectors, directed corner sequences, random vs model.
module tb_multichannel_inputconditioner;

  localparam int         CH    = 4;
  localparam int         CW    = 3;
  localparam int         GW    = 4;
  localparam logic [3:0] INITV = 4'b0101;
  localparam logic [3:0] INV   = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    noisysignal = 4'b1101;
  logic [3:0]    enable = 4'hF;
  logic [2:0]    waittime = 3'd3;
  logic          glitchclear = 1'b0;
  logic [3:0]    conditioned, positiveedge, negativeedge;
  logic          anyposedge, anynegedge;
  logic [15:0]   glitchcount;

  int n_checks = 0;
  int n_fail   = 0;

  multichannel_inputconditioner #(
    .CHANNELS(CH), .COUNTERWIDTH(CW), .INITVAL(INITV), .INVERT(INV), .GLITCHWIDTH(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .noisysignal(noisysignal), .enable(enable),
    .waittime(waittime), .glitchclear(glitchclear), .conditioned(conditioned),
    .positiveedge(positiveedge), .negativeedge(negativeedge), .anyposedge(anyposedge),
    .anynegedge(anynegedge), .glitchcount(glitchcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] noisy;
    logic [3:0] en;
    logic [2:0] wt;
    int         n;
    logic [3:0] cond;
    logic [3:0] pos;
    logic [3:0] neg;
  } vec_t;

  vec_t tbl[12];

  // Behavioural reference: compare at edge k sees the input sampled at edge k-2.
  logic [3:0] m_q[$];
  logic [3:0] m_cond, m_pos, m_neg;
  int         m_run[4];
  int         m_gl[4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_glitch(input logic [15:0] g);
`ifdef GLITCH_COUNT_EN
    return g;
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_reset();
    m_cond = INITV;
    m_pos  = '0;
    m_neg  = '0;
    m_q    = {INITV, INITV};
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0;
      m_gl[i]  = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] ns, input logic [3:0] en, input int wt,
                            input logic gc);
    logic [3:0] v;
    logic [3:0] ab;
    v  = m_q[0];
    void'(m_q.pop_front());
    m_q.push_back(ns ^ INV);
    m_pos = '0;
    m_neg = '0;
    ab    = '0;
    for (int i = 0; i < 4; i++) begin
      if (!en[i]) m_run[i] = 0;
      else if (v[i] == m_cond[i]) begin
        ab[i]    = (m_run[i] != 0);
        m_run[i] = 0;
      end else if (m_run[i] >= wt) begin
        m_cond[i] = v[i];
        if (v[i]) m_pos[i] = 1'b1;
        else      m_neg[i] = 1'b1;
        m_run[i] = 0;
      end else m_run[i] = m_run[i] + 1;
      if (gc) m_gl[i] = 0;
      else if (ab[i] && m_gl[i] < 15) m_gl[i] = m_gl[i] + 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] gexp;
    int          ci;
    // ---- reset, asynchronous entry, no spurious edges on release
    #2 rst_n = 1'b0;
    #1;
    chk("reset_cond", conditioned, INITV);
    chk("reset_pulses", {positiveedge, negativeedge, 6'b0, anyposedge, anynegedge}, 16'h0);
    chk("reset_glitch", glitchcount, 16'h0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("post_reset_quiet", {conditioned, positiveedge, negativeedge, 2'b0, anyposedge, anynegedge},
          {INITV, 8'h00, 4'h0});
    end

    // ---- table-driven vectors
    tbl[0]  = '{4'b1100, 4'hF, 3'd3, 5, 4'b0101, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1100, 4'hF, 3'd3, 1, 4'b0100, 4'b0000, 4'b0001};
    tbl[2]  = '{4'b1100, 4'hF, 3'd3, 1, 4'b0100, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1101, 4'hF, 3'd3, 5, 4'b0100, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1101, 4'hF, 3'd3, 1, 4'b0101, 4'b0001, 4'b0000};
    tbl[5]  = '{4'b1101, 4'hF, 3'd3, 1, 4'b0101, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1111, 4'hF, 3'd0, 2, 4'b0101, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b1111, 4'hF, 3'd0, 1, 4'b0111, 4'b0010, 4'b0000};
    tbl[8]  = '{4'b1111, 4'hF, 3'd0, 1, 4'b0111, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1101, 4'hF, 3'd0, 2, 4'b0111, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1101, 4'hF, 3'd0, 1, 4'b0101, 4'b0000, 4'b0010};
    tbl[11] = '{4'b1101, 4'hF, 3'd3, 4, 4'b0101, 4'b0000, 4'b0000};
    for (int t = 0; t < 12; t++) begin
      noisysignal = tbl[t].noisy;
      enable      = tbl[t].en;
      waittime    = tbl[t].wt;
      for (int c = 0; c < tbl[t].n; c++) step();
      chk($sformatf("vec%0d_cond", t), conditioned, tbl[t].cond);
      chk($sformatf("vec%0d_pulses", t), {positiveedge, negativeedge, 6'b0, anyposedge, anynegedge},
          {tbl[t].pos, tbl[t].neg, 6'b0, |tbl[t].pos, |tbl[t].neg});
    end

    // ---- bounce on channel 1: toggles then hold high, rise 6 edges after final change
    noisysignal[1] = 1'b1; step();
    chk("bounce_quiet_a", {positiveedge, negativeedge}, 8'h0);
    noisysignal[1] = 1'b0; step();
    chk("bounce_quiet_b", {positiveedge, negativeedge}, 8'h0);
    noisysignal[1] = 1'b1; step();
    chk("bounce_quiet_c", {positiveedge, negativeedge}, 8'h0);
    noisysignal[1] = 1'b0; step();
    chk("bounce_quiet_d", {positiveedge, negativeedge}, 8'h0);
    noisysignal[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("bounce_hold", {conditioned, positiveedge, negativeedge}, {4'b0101, 8'h0});
    end
    step();
    chk("bounce_rise", {conditioned, positiveedge, negativeedge, anyposedge}, {4'b0111, 4'b0010, 4'b0, 1'b1});
    step();
    chk("bounce_pulse_once", {positiveedge, anyposedge}, 5'b0);
    chk("bounce_glitch", glitchcount, exp_glitch(16'h0020));

    // ---- enable mask with inverted channel 3
    enable[3] = 1'b0;
    noisysignal[3] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("disabled_hold", {conditioned, positiveedge, negativeedge}, {4'b0111, 8'h0});
    end
    enable[3] = 1'b1;
    step(); step(); step();
    chk("reenable_wait", {conditioned, positiveedge}, {4'b0111, 4'b0000});
    step();
    chk("reenable_rise", {conditioned, positiveedge, anyposedge}, {4'b1111, 4'b1000, 1'b1});

    // ---- asynchronous reset while channel 2 is mid-debounce
    noisysignal[2] = 1'b0;
    step(); step(); step(); step();
    chk("midcount_hold", conditioned, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_cond", conditioned, INITV);
    chk("async_reset_pulses", {positiveedge, negativeedge, 6'b0, anyposedge, anynegedge}, 16'h0);
    chk("async_reset_glitch", glitchcount, 16'h0);
    noisysignal = 4'b1101;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("release_quiet", {conditioned, positiveedge, negativeedge}, {INITV, 8'h0});
    end
    noisysignal = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("fresh_count", {conditioned, negativeedge}, {INITV, 4'b0});
    end
    step();
    chk("fresh_fall", {conditioned, negativeedge, anynegedge}, {4'b0001, 4'b0100, 1'b1});

    // ---- glitch saturation and clear on channel 0
    glitchclear = 1'b1; step(); glitchclear = 1'b0;
    chk("gclear_initial", glitchcount, 16'h0);
    for (int c = 0; c < 50; c++) begin
      noisysignal[0] = ~noisysignal[0];
      step();
      chk("toggle_no_pulse", {positiveedge[0], negativeedge[0]}, 2'b00);
    end
    noisysignal[0] = 1'b1;
    step(); step(); step(); step();
    chk("glitch_saturate", glitchcount, exp_glitch(16'h000F));
    chk("toggle_cond_hold", conditioned, 4'b0001);
    glitchclear = 1'b1; step(); glitchclear = 1'b0;
    chk("glitch_clear", glitchcount, 16'h0);

    // ---- randomized run against the behavioural model
    rst_n = 1'b0;
    noisysignal = 4'b1101;
    enable = 4'hF;
    waittime = 3'd2;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      ci = ((c % 80) < 30) ? 1 : 12;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(ci) == 0) noisysignal[b] = ~noisysignal[b];
      for (int b = 0; b < 4; b++) enable[b] = ($urandom_range(9) != 0);
      if ($urandom_range(40) == 0) waittime = 3'($urandom_range(7));
      glitchclear = ($urandom_range(60) == 0);
      model_edge(noisysignal, enable, int'(waittime), glitchclear);
      step();
      gexp = {4'(m_gl[3]), 4'(m_gl[2]), 4'(m_gl[1]), 4'(m_gl[0])};
      chk("rand_cond", conditioned, m_cond);
      chk("rand_pulses", {positiveedge, negativeedge, 6'b0, anyposedge, anynegedge},
          {m_pos, m_neg, 6'b0, |m_pos, |m_neg});
      chk("rand_glitch", glitchcount, exp_glitch(gexp));
    end
    glitchclear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multichannel_inputconditioner.md
Name: multichannel_inputconditioner

Overview:
- Parametrised successor to the single-input conditioner: conditions CHANNELS independent noisy inputs in one clock domain.
- Each channel has its own two-flop synchroniser, its own debounce counter and its own one-cycle rising and falling edge pulses.
- Adds asynchronous active-low reset, a run-time debounce length, a per-channel enable mask, per-channel polarity inversion, and aggregate any-edge outputs.
- Sits between the board pins (buttons, switches) and the datapath or control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
COUNTERWIDTH, 3, debounce counter width in bits; must hold the largest waittime used
INITVAL, 0 (CHANNELS bits), reset value of each channel's conditioned output
INVERT, 0 (CHANNELS bits), bit i = 1 inverts channel i at the input, ahead of the synchroniser
GLITCHWIDTH, 4, width of each per-channel glitch counter (optional feature only)

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  asynchronous, active-low reset
noisysignal  input  CHANNELS  raw, possibly bouncing inputs
enable  input  CHANNELS  per-channel enable; 0 freezes the channel
waittime  input  COUNTERWIDTH  debounce length in cycles, sampled live every cycle
glitchclear  input  1  synchronous clear of all glitch counters
conditioned  output  CHANNELS  debounced, synchronised level
positiveedge  output  CHANNELS  1-cycle pulse when conditioned rises
negativeedge  output  CHANNELS  1-cycle pulse when conditioned falls
anyposedge  output  1  OR of all positiveedge bits
anynegedge  output  1  OR of all negativeedge bits
glitchcount  output  CHANNELS*GLITCHWIDTH  channel i occupies bits [i*GLITCHWIDTH +: GLITCHWIDTH]

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately and also mid-debounce):
  - synchroniser stages and conditioned go to INITVAL.
  - counters go to 0; all edge pulses and any-edge outputs go to 0; glitch counters go to 0.
  - Because the synchroniser resets to INITVAL, leaving reset does not produce a spurious edge.
- Per channel i, the input value is s = noisysignal[i] ^ INVERT[i]. Each cycle: sync0 <= s, then sync1 <= sync0.
- Debounce, enabled channel:
  - sync1 == conditioned: counter <= 0.
  - sync1 != conditioned and counter < waittime: counter <= counter + 1.
  - sync1 != conditioned and counter >= waittime: conditioned <= sync1, counter <= 0, and the matching edge pulse is set high.
  - The `>=` comparison means lowering waittime mid-count commits on the next mismatching cycle.
  - The counter never wraps; the compare fires before overflow.
- Latency, input stable after a change with waittime = W: conditioned changes on the (W+3)th rising edge, counting the first edge that samples the new value as edge 1.
  - W = 0 gives 3 edges.
  - Any return to agreement before commit restarts the count from 0.
- Edge pulses:
  - positiveedge[i] or negativeedge[i] is high for exactly one cycle, in the same cycle conditioned[i] changes.
  - The two are never both high for one channel.
  - Back-to-back transitions are at least W+1 cycles apart, so pulses never merge.
- Disabled channel (enable[i] = 0):
  - synchroniser keeps running; counter held at 0; conditioned holds its value; no pulses.
  - When re-enabled, debounce starts fresh from a count of 0.
- anyposedge and anynegedge are combinational ORs of the registered pulse vectors, with no extra latency.
- Channels are fully independent; simultaneous events on several channels each produce their own pulse.

Optional Feature:
GLITCH_COUNT_EN
- Defined:
  - A glitch is a cycle where counter[i] != 0 and sync1 == conditioned, i.e. a debounce attempt aborted.
  - Each glitch increments channel i's glitch counter.
  - Counters saturate at 2^GLITCHWIDTH - 1.
  - glitchclear zeroes all counters synchronously and takes priority over an increment in the same cycle.
  - Disabled channels do not count.
- Not defined: glitchcount is driven constant 0, glitchclear is ignored, and no counter flops are synthesised. Ports are present in both builds.

Test Plan:
- Reset: CHANNELS=4, INITVAL=4'b0101, rst_n low then released with noisysignal=4'b0101 -> conditioned=4'b0101; no pulses for 20 cycles.
- Clean step: waittime=3, noisysignal[0] goes 0->1 and is held -> conditioned[0] rises on edge 6; positiveedge[0] and anyposedge high for that one cycle only.
- Bounce: waittime=3, noisysignal[1] toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during the bounce; conditioned[1] rises 6 edges after the final change. With GLITCH_COUNT_EN, glitchcount[1] > 0.
- Enable and invert: INVERT=4'b1000, enable[3]=0 while noisysignal[3] goes 1->0 -> conditioned[3] stays 0. Set enable[3]=1 -> conditioned[3] goes to 1 with positiveedge[3] 4 edges later at waittime=3, debounce restarting from 0.
- Reset mid-operation: assert rst_n low for 1 cycle while channel 2's counter=2 -> counter and conditioned[2] return to INITVAL immediately and asynchronously; no pulse emitted.
- Saturation (GLITCH_COUNT_EN, GLITCHWIDTH=4): 20 glitches on channel 0 -> glitchcount[3:0]=15. Pulse glitchclear -> 0.
